// File: rtl/note_player_pkg.sv
// Shared types and fixed widths for the enveloped note player.
package note_player_pkg;

  localparam int NOTE_W   = 6;
  localparam int SAMPLE_W = 16;
  localparam int STEP_W   = 20;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_SUSTAIN,
    ST_RELEASE,
    ST_REST,
    ST_DONE
  } env_state_t;

  // States in which the oscillator is audible and the phase may advance.
  function automatic logic is_voiced(input env_state_t s);
    return (s == ST_ATTACK) || (s == ST_SUSTAIN) || (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/note_player_if.sv
// Note/beat/sample handshake bundle between song reader, note player and codec path.
interface note_player_if #(
  parameter int DUR_W  = 6,
  parameter int GAIN_W = 4
);
  import note_player_pkg::*;

  logic                       play_enable;
  logic [NOTE_W-1:0]          note_to_load;
  logic [DUR_W-1:0]           duration_to_load;
  logic                       load_new_note;
  logic                       beat;
  logic                       generate_next_sample;
  logic                       note_ready;
  logic                       done_with_note;
  logic signed [SAMPLE_W-1:0] sample_out;
  logic                       new_sample_ready;
  logic [GAIN_W-1:0]          gain_out;

  modport master (
    output play_enable, note_to_load, duration_to_load, load_new_note, beat,
           generate_next_sample,
    input  note_ready, done_with_note, sample_out, new_sample_ready, gain_out
  );

  modport slave (
    input  play_enable, note_to_load, duration_to_load, load_new_note, beat,
           generate_next_sample,
    output note_ready, done_with_note, sample_out, new_sample_ready, gain_out
  );

endinterface

// File: rtl/frequency_rom.sv
// Note index to phase step table, one cycle of read latency.
module frequency_rom
  import note_player_pkg::*;
(
  input  logic              clk,
  input  logic [NOTE_W-1:0] note,
  output logic [STEP_W-1:0] step
);

  always_ff @(posedge clk)
    step <= STEP_W'({note, 12'd0});

endmodule

// File: rtl/note_player_env_envelope_gen.sv
// Beat-driven note state machine: remaining-beat counter and linear A/S/R gain.
module envelope_gen
  import note_player_pkg::*;
#(
  parameter int DUR_W         = 6,
  parameter int GAIN_W        = 4,
  parameter int ATTACK_INC    = 1,
  parameter int RELEASE_DEC   = 1,
  parameter int RELEASE_BEATS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  duration_in,
  input  logic              beat,
  output env_state_t        state,
  output logic [NOTE_W-1:0] note_q,
  output logic [GAIN_W-1:0] gain,
  output logic              note_ready,
  output logic              done_with_note
);

  localparam logic [GAIN_W:0]   GAIN_MAX  = {1'b0, {GAIN_W{1'b1}}};
  localparam logic [GAIN_W-1:0] GAIN_FULL = {GAIN_W{1'b1}};
  localparam logic [GAIN_W:0]   INC       = (GAIN_W+1)'(ATTACK_INC);
  localparam logic [GAIN_W:0]   DEC       = (GAIN_W+1)'(RELEASE_DEC);
  localparam logic [DUR_W-1:0]  REL_TH    = DUR_W'(RELEASE_BEATS);

  logic [DUR_W-1:0] rem;
  logic [DUR_W-1:0] rem_dec;
  logic             accept;
  logic             counted;

  function automatic logic [GAIN_W-1:0] sat_add(input logic [GAIN_W-1:0] g);
    logic [GAIN_W:0] s;
    s = {1'b0, g} + INC;
    return (s > GAIN_MAX) ? GAIN_FULL : s[GAIN_W-1:0];
  endfunction

  function automatic logic [GAIN_W-1:0] sat_sub(input logic [GAIN_W-1:0] g);
    return ({1'b0, g} < DEC) ? '0 : (g - DEC[GAIN_W-1:0]);
  endfunction

  // A load in the same cycle as a beat swallows the beat.
  assign accept  = load_new_note & note_ready;
  assign counted = beat & play_enable & ~accept;
  assign rem_dec = rem - 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      rem            <= '0;
      gain           <= '0;
      note_q         <= '0;
      note_ready     <= 1'b1;
      done_with_note <= 1'b0;
    end else if (accept) begin
      note_q <= note_in;
      rem    <= duration_in;
      gain   <= '0;
      if (duration_in == '0) begin
        state          <= ST_DONE;
        note_ready     <= 1'b1;
        done_with_note <= 1'b1;
      end else begin
        state          <= (note_in == REST_NOTE) ? ST_REST : ST_ATTACK;
        note_ready     <= 1'b0;
        done_with_note <= 1'b0;
      end
    end else if (counted && (is_voiced(state) || state == ST_REST)) begin
      rem <= rem_dec;
      if (rem == DUR_W'(1)) begin
        state          <= ST_DONE;
        gain           <= '0;
        note_ready     <= 1'b1;
        done_with_note <= 1'b1;
      end else begin
        case (state)
          ST_ATTACK, ST_SUSTAIN: begin
            if (rem_dec <= REL_TH) begin
              state <= ST_RELEASE;
              gain  <= sat_sub(gain);
            end else if (state == ST_ATTACK) begin
              gain <= sat_add(gain);
              if (sat_add(gain) == GAIN_FULL) state <= ST_SUSTAIN;
            end
          end
          ST_RELEASE: gain <= sat_sub(gain);
          default:    gain <= '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/sine_reader.sv
// Phase accumulator plus quarter-wave sine table; answers each request one cycle later.
module sine_reader
  import note_player_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       generate_next_sample,
  input  logic [STEP_W-1:0]          step,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_ready
);

  localparam logic [14:0] QTAB [0:16] = '{
    15'd0,     15'd3212,  15'd6393,  15'd9512,  15'd12539, 15'd15446,
    15'd18204, 15'd20787, 15'd23170, 15'd25329, 15'd27245, 15'd28898,
    15'd30273, 15'd31356, 15'd32137, 15'd32609, 15'd32767
  };

  logic [STEP_W-1:0] phase;

  // 64 points per cycle: top two index bits pick the quadrant, the rest mirror the table.
  function automatic logic signed [SAMPLE_W-1:0] lookup(input logic [5:0] idx);
    logic [4:0]  k;
    logic [14:0] mag;
    k   = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
    mag = QTAB[k];
    return idx[5] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase        <= '0;
      sample       <= '0;
      sample_ready <= 1'b0;
    end else begin
      sample_ready <= generate_next_sample;
      if (generate_next_sample) begin
        sample <= lookup(phase[STEP_W-1 -: 6]);
        phase  <= phase + step;
      end
    end
  end

endmodule

// File: rtl/note_player_env.sv
// Single-voice note player with A/S/R envelope: ROM -> sine reader -> gain scaling register.
module note_player_env
  import note_player_pkg::*;
#(
  parameter int DUR_W         = 6,
  parameter int GAIN_W        = 4,
  parameter int ATTACK_INC    = 1,
  parameter int RELEASE_DEC   = 1,
  parameter int RELEASE_BEATS = 3
) (
  input logic         clk,
  input logic         reset,
  note_player_if.slave bus
);

  localparam int PW = SAMPLE_W + GAIN_W + 1;

  env_state_t                 state;
  logic [NOTE_W-1:0]          note_q;
  logic [GAIN_W-1:0]          gain;
  logic [STEP_W-1:0]          rom_step;
  logic [STEP_W-1:0]          step;
  logic signed [SAMPLE_W-1:0] raw_p0;
  logic                       vld_p0;
  logic signed [SAMPLE_W-1:0] sample_p1;
  logic                       vld_p1;

  function automatic logic signed [SAMPLE_W-1:0] scale_gain(
    input logic signed [SAMPLE_W-1:0] raw,
    input logic [GAIN_W-1:0]          g
  );
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    logic signed [PW-1:0] prod;
    a    = PW'(raw);
    b    = $signed(PW'(g));
    prod = a * b;
    return $signed(prod[GAIN_W +: SAMPLE_W]);
  endfunction

  envelope_gen #(
    .DUR_W(DUR_W), .GAIN_W(GAIN_W), .ATTACK_INC(ATTACK_INC),
    .RELEASE_DEC(RELEASE_DEC), .RELEASE_BEATS(RELEASE_BEATS)
  ) u_env (
    .clk(clk), .reset(reset), .play_enable(bus.play_enable),
    .load_new_note(bus.load_new_note), .note_in(bus.note_to_load),
    .duration_in(bus.duration_to_load), .beat(bus.beat),
    .state(state), .note_q(note_q), .gain(gain),
    .note_ready(bus.note_ready), .done_with_note(bus.done_with_note)
  );

  frequency_rom u_rom (.clk(clk), .note(note_q), .step(rom_step));

  // Zero step freezes the phase during rests, idle/done and while paused.
  assign step = (is_voiced(state) && bus.play_enable) ? rom_step : '0;

  sine_reader u_sine (
    .clk(clk), .reset(reset), .generate_next_sample(bus.generate_next_sample),
    .step(step), .sample(raw_p0), .sample_ready(vld_p0)
  );

  // Stage p0 -> p1: apply envelope gain to the raw sine sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) sample_p1 <= scale_gain(raw_p0, gain);
    end
  end

  assign bus.sample_out       = sample_p1;
  assign bus.new_sample_ready = vld_p1;
  assign bus.gain_out         = gain;

endmodule

// File: tb/tb_note_player_env.sv
// Scoreboard bench for note_player_env: directed notes, envelope steps and scaled samples.
module tb_note_player_env;
  import note_player_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  note_player_if #(.DUR_W(6), .GAIN_W(4)) bus ();

  note_player_env #(
    .DUR_W(6), .GAIN_W(4), .ATTACK_INC(1), .RELEASE_DEC(1), .RELEASE_BEATS(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    string name;
    int    gain;
    int    ready;
    int    done;
    bit    chk_smp;
    int    smp;
  } exp_t;

  exp_t  q_st[$];
  int    q_smp[$];
  string q_smp_name[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic expect_st(input string n, input int g, input int r, input int d,
                           input bit cs = 1'b0, input int s = 0);
    exp_t e;
    e.name = n; e.gain = g; e.ready = r; e.done = d; e.chk_smp = cs; e.smp = s;
    q_st.push_back(e);
  endtask

  // State monitor: one expectation per beat/load/reset event seen at a clock edge.
  initial begin : mon_state
    logic ev;
    exp_t e;
    forever begin
      @(posedge clk);
      ev = bus.beat | bus.load_new_note | reset;
      @(negedge clk);
      if (ev) begin
        if (q_st.size() == 0) check("orphan_event", 1, 0);
        else begin
          e = q_st.pop_front();
          check({e.name, "_gain"},  int'(bus.gain_out),       e.gain);
          check({e.name, "_ready"}, int'(bus.note_ready),     e.ready);
          check({e.name, "_done"},  int'(bus.done_with_note), e.done);
          if (e.chk_smp) check({e.name, "_sample"}, int'(bus.sample_out), e.smp);
        end
      end
    end
  end

  // Sample monitor: one expectation per new_sample_ready pulse.
  initial begin : mon_sample
    forever begin
      @(negedge clk);
      if (bus.new_sample_ready) begin
        if (q_smp.size() == 0) check("orphan_sample", 1, 0);
        else check(q_smp_name.pop_front(), int'(bus.sample_out), q_smp.pop_front());
      end
    end
  end

  task automatic pulse_beat();
    @(negedge clk); bus.beat = 1'b1;
    @(negedge clk); bus.beat = 1'b0;
  endtask

  task automatic load(input int n, input int d, input bit with_beat);
    @(negedge clk);
    bus.note_to_load     = 6'(n);
    bus.duration_to_load = 6'(d);
    bus.load_new_note    = 1'b1;
    bus.beat             = with_beat;
    @(negedge clk);
    bus.load_new_note = 1'b0;
    bus.beat          = 1'b0;
  endtask

  task automatic req(input int s, input string n);
    q_smp.push_back(s);
    q_smp_name.push_back(n);
    @(negedge clk); bus.generate_next_sample = 1'b1;
    @(negedge clk); bus.generate_next_sample = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q_smp.size() != 0; i++) @(negedge clk);
    if (q_smp.size() != 0) begin
      check("sample_timeout", q_smp.size(), 0);
      q_smp.delete();
      q_smp_name.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin : stim
    int g;
    bus.play_enable          = 1'b1;
    bus.note_to_load         = '0;
    bus.duration_to_load     = '0;
    bus.load_new_note        = 1'b0;
    bus.beat                 = 1'b0;
    bus.generate_next_sample = 1'b0;

    expect_st("rst_init", 0, 1, 0, 1'b1, 0);
    @(negedge clk); reset = 1'b0;

    // Reset in the middle of an attack
    expect_st("t1_load", 0, 0, 0); load(20, 30, 1'b0);
    expect_st("t1_b1", 1, 0, 0); pulse_beat();
    expect_st("t1_b2", 2, 0, 0); pulse_beat();
    req(0, "t1_s0");
    req(1930, "t1_s1");
    drain();
    expect_st("t1_rst", 0, 1, 0, 1'b1, 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;

    // Short note: release before gain can saturate
    expect_st("t2_load", 0, 0, 0); load(20, 5, 1'b0);
    expect_st("t2_b1", 1, 0, 0); pulse_beat();
    expect_st("t2_b2", 0, 0, 0); pulse_beat();
    expect_st("t2_b3", 0, 0, 0); pulse_beat();
    expect_st("t2_b4", 0, 0, 0); pulse_beat();
    expect_st("t2_b5", 0, 1, 1); pulse_beat();

    // Zero duration
    expect_st("t3_load", 0, 1, 1); load(20, 0, 1'b0);

    // Rest note
    expect_st("t4_load", 0, 0, 0); load(0, 4, 1'b0);
    req(0, "t4_s0");
    req(0, "t4_s1");
    drain();
    expect_st("t4_b1", 0, 0, 0, 1'b1, 0); pulse_beat();
    expect_st("t4_b2", 0, 0, 0, 1'b1, 0); pulse_beat();
    expect_st("t4_b3", 0, 0, 0, 1'b1, 0); pulse_beat();
    expect_st("t4_b4", 0, 1, 1, 1'b1, 0); pulse_beat();

    // Long note: load+beat, busy load, sustain, pause, release, done
    expect_st("t5_load_beat", 0, 0, 0); load(20, 30, 1'b1);
    expect_st("t5_busy_load", 1, 0, 0); load(0, 2, 1'b1);
    for (int k = 2; k <= 16; k++) begin
      expect_st($sformatf("t5_b%0d", k), (k > 15) ? 15 : k, 0, 0);
      pulse_beat();
    end
    req(0, "t5_s0");
    req(14480, "t5_s1");
    drain();
    @(negedge clk); bus.play_enable = 1'b0;
    req(25542, "t5_s2");
    req(25542, "t5_s3");
    drain();
    for (int k = 0; k < 10; k++) begin
      expect_st($sformatf("t5_frz%0d", k), 15, 0, 0, 1'b1, 25542);
      pulse_beat();
    end
    @(negedge clk); bus.play_enable = 1'b1;
    for (int k = 17; k <= 29; k++) begin
      g = (k <= 26) ? 15 : (k == 27) ? 14 : (k == 28) ? 13 : 12;
      expect_st($sformatf("t5_b%0d", k), g, 0, 0);
      pulse_beat();
    end
    expect_st("t5_b30", 0, 1, 1); pulse_beat();
    expect_st("t5_done_hold", 0, 1, 1); pulse_beat();

    for (int i = 0; i < 10 && q_st.size() != 0; i++) @(negedge clk);
    check("pending_state_checks", q_st.size(), 0);
    drain();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
